// File: rtl/lc3b_types.sv
// Shared LC-3b types: opcodes, ALU operations, control-FSM states and the
// datapath control word driven by lc3b_control.
package lc3b_types;

  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldr  = 4'b0110,
    op_str  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;

  typedef enum logic [2:0] {
    alu_add  = 3'd0,
    alu_and  = 3'd1,
    alu_not  = 3'd2,
    alu_pass = 3'd3,
    alu_sll  = 3'd4,
    alu_srl  = 3'd5,
    alu_sra  = 3'd6
  } lc3b_aluop;

  typedef enum logic [3:0] {
    st_fetch1,
    st_fetch2,
    st_fetch3,
    st_decode,
    st_add,
    st_and,
    st_not,
    st_br,
    st_br_taken,
    st_calc_addr,
    st_ldr1,
    st_ldr2,
    st_str1,
    st_str2,
    st_error
  } lc3b_ctrl_state;

  localparam int unsigned LC3B_MEM_TIMEOUT_DFLT = 255;

  // One cycle's worth of datapath and memory controls.
  typedef struct packed {
    logic      load_pc;
    logic      load_ir;
    logic      load_regfile;
    logic      load_mar;
    logic      load_mdr;
    logic      load_cc;
    logic      pcmux_sel;
    logic      storemux_sel;
    logic      alumux_sel;
    logic      regfilemux_sel;
    logic      marmux_sel;
    logic      mdrmux_sel;
    lc3b_aluop aluop;
    logic      mem_read;
    logic      mem_write;
  } lc3b_ctrl_t;

  // States that sit waiting on mem_resp and are covered by the watchdog.
  function automatic logic is_mem_wait(input lc3b_ctrl_state s);
    return (s == st_fetch2) || (s == st_ldr1) || (s == st_str2);
  endfunction

endpackage

// File: rtl/lc3b_mem_watchdog.sv
// Counts consecutive unanswered cycles in a memory wait state and flags
// expiry on the cycle the count reaches TIMEOUT; TIMEOUT=0 disables it.
module lc3b_mem_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic count_en,
  input  logic resp,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned LAST  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en && !resp) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A response in the final cycle still wins over expiry.
  assign expired = (TIMEOUT != 0) && count_en && !resp && (cnt_q == CNT_W'(LAST));

endmodule

// File: rtl/lc3b_control.sv
// Multicycle Moore control FSM for the LC-3b mp0 core (ADD/AND/NOT/BR/LDR/STR)
// with a memory-response watchdog that parks the core in a sticky error state.
module lc3b_control
  import lc3b_types::*;
#(
  parameter int unsigned MEM_TIMEOUT = LC3B_MEM_TIMEOUT_DFLT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] opcode,
  input  logic       branch_enable,
  input  logic       mem_resp,
  output logic       load_pc,
  output logic       load_ir,
  output logic       load_regfile,
  output logic       load_mar,
  output logic       load_mdr,
  output logic       load_cc,
  output logic       pcmux_sel,
  output logic       storemux_sel,
  output logic       alumux_sel,
  output logic       regfilemux_sel,
  output logic       marmux_sel,
  output logic       mdrmux_sel,
  output logic [2:0] aluop,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_error
);

  lc3b_ctrl_state state_q, state_d;
  lc3b_ctrl_t     ctrl;
  logic           active_q;
  logic           mem_error_q;
  logic           wd_clear, wd_count_en, wd_expired;

  // active_q holds outputs low until the first edge after reset release, so
  // every control drops asynchronously with reset_n and FETCH1 gets a full cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= st_fetch1;
      active_q    <= 1'b0;
      mem_error_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= 1'b1;
      if (state_q == st_error) begin
        mem_error_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ctrl       = '0;
    ctrl.aluop = alu_add;
    if (active_q) begin
      case (state_q)
        st_fetch1: begin
          ctrl.marmux_sel = 1'b0;
          ctrl.load_mar   = 1'b1;
          ctrl.pcmux_sel  = 1'b0;
          ctrl.load_pc    = 1'b1;
          state_d         = st_fetch2;
        end
        st_fetch2: begin
          ctrl.mem_read   = 1'b1;
          ctrl.mdrmux_sel = 1'b0;
          ctrl.load_mdr   = 1'b1;
          if (mem_resp)        state_d = st_fetch3;
          else if (wd_expired) state_d = st_error;
        end
        st_fetch3: begin
          ctrl.load_ir = 1'b1;
          state_d      = st_decode;
        end
        st_decode: begin
          case (lc3b_opcode'(opcode))
            op_add:         state_d = st_add;
            op_and:         state_d = st_and;
            op_not:         state_d = st_not;
            op_br:          state_d = st_br;
            op_ldr, op_str: state_d = st_calc_addr;
            default:        state_d = st_fetch1;
          endcase
        end
        st_add, st_and, st_not: begin
          ctrl.aluop          = (state_q == st_add) ? alu_add :
                                (state_q == st_and) ? alu_and : alu_not;
          ctrl.alumux_sel     = 1'b0;
          ctrl.regfilemux_sel = 1'b0;
          ctrl.load_regfile   = 1'b1;
          ctrl.load_cc        = 1'b1;
          state_d             = st_fetch1;
        end
        st_br: begin
          state_d = branch_enable ? st_br_taken : st_fetch1;
        end
        st_br_taken: begin
          ctrl.pcmux_sel = 1'b1;
          ctrl.load_pc   = 1'b1;
          state_d        = st_fetch1;
        end
        st_calc_addr: begin
          ctrl.storemux_sel = 1'b0;
          ctrl.alumux_sel   = 1'b1;
          ctrl.aluop        = alu_add;
          ctrl.marmux_sel   = 1'b1;
          ctrl.load_mar     = 1'b1;
          state_d = (lc3b_opcode'(opcode) == op_ldr) ? st_ldr1 : st_str1;
        end
        st_ldr1: begin
          ctrl.mem_read   = 1'b1;
          ctrl.mdrmux_sel = 1'b0;
          ctrl.load_mdr   = 1'b1;
          if (mem_resp)        state_d = st_ldr2;
          else if (wd_expired) state_d = st_error;
        end
        st_ldr2: begin
          ctrl.regfilemux_sel = 1'b1;
          ctrl.load_regfile   = 1'b1;
          ctrl.load_cc        = 1'b1;
          state_d             = st_fetch1;
        end
        st_str1: begin
          ctrl.storemux_sel = 1'b1;
          ctrl.aluop        = alu_pass;
          ctrl.mdrmux_sel   = 1'b1;
          ctrl.load_mdr     = 1'b1;
          state_d           = st_str2;
        end
        st_str2: begin
          ctrl.mem_write = 1'b1;
          if (mem_resp)        state_d = st_fetch1;
          else if (wd_expired) state_d = st_error;
        end
        st_error: begin
          state_d = st_error;
        end
        default: begin
          state_d = st_fetch1;
        end
      endcase
    end
  end

  // Wait states are only ever entered from non-wait states, so clear on entry.
  assign wd_count_en = active_q && is_mem_wait(state_q);
  assign wd_clear    = is_mem_wait(state_d) && (state_d != state_q);

  lc3b_mem_watchdog #(
    .TIMEOUT (MEM_TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (wd_clear),
    .count_en (wd_count_en),
    .resp     (mem_resp),
    .expired  (wd_expired)
  );

  assign load_pc        = ctrl.load_pc;
  assign load_ir        = ctrl.load_ir;
  assign load_regfile   = ctrl.load_regfile;
  assign load_mar       = ctrl.load_mar;
  assign load_mdr       = ctrl.load_mdr;
  assign load_cc        = ctrl.load_cc;
  assign pcmux_sel      = ctrl.pcmux_sel;
  assign storemux_sel   = ctrl.storemux_sel;
  assign alumux_sel     = ctrl.alumux_sel;
  assign regfilemux_sel = ctrl.regfilemux_sel;
  assign marmux_sel     = ctrl.marmux_sel;
  assign mdrmux_sel     = ctrl.mdrmux_sel;
  assign aluop          = ctrl.aluop;
  assign mem_read       = ctrl.mem_read;
  assign mem_write      = ctrl.mem_write;
  assign mem_error      = mem_error_q;

endmodule

// File: tb/tb_lc3b_control.sv
// Bench for lc3b_control: each instruction is expanded into the expected
// per-cycle control words, then replayed with random waits and input noise.
module tb_lc3b_control;
  import lc3b_types::*;

  localparam int unsigned TIMEOUT = 4;

  localparam logic [17:0] LPC  = 18'h20000;
  localparam logic [17:0] LIR  = 18'h10000;
  localparam logic [17:0] LRF  = 18'h08000;
  localparam logic [17:0] LMAR = 18'h04000;
  localparam logic [17:0] LMDR = 18'h02000;
  localparam logic [17:0] LCC  = 18'h01000;
  localparam logic [17:0] PCM  = 18'h00800;
  localparam logic [17:0] STM  = 18'h00400;
  localparam logic [17:0] ALM  = 18'h00200;
  localparam logic [17:0] RFM  = 18'h00100;
  localparam logic [17:0] MARM = 18'h00080;
  localparam logic [17:0] MDRM = 18'h00040;
  localparam logic [17:0] RD   = 18'h00004;
  localparam logic [17:0] WR   = 18'h00002;
  localparam logic [17:0] ERRB = 18'h00001;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] opcode;
  logic       branch_enable;
  logic       mem_resp;
  logic       load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc;
  logic       pcmux_sel, storemux_sel, alumux_sel, regfilemux_sel, marmux_sel, mdrmux_sel;
  logic [2:0] aluop;
  logic       mem_read, mem_write, mem_error;
  logic [17:0] obs;

  int vectors = 0;
  int miscompares = 0;

  logic [17:0] exp_q[$];
  logic        resp_q[$];
  logic [3:0]  op_q[$];
  logic        be_q[$];
  string       tag_q[$];

  lc3b_control #(
    .MEM_TIMEOUT (TIMEOUT)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .opcode         (opcode),
    .branch_enable  (branch_enable),
    .mem_resp       (mem_resp),
    .load_pc        (load_pc),
    .load_ir        (load_ir),
    .load_regfile   (load_regfile),
    .load_mar       (load_mar),
    .load_mdr       (load_mdr),
    .load_cc        (load_cc),
    .pcmux_sel      (pcmux_sel),
    .storemux_sel   (storemux_sel),
    .alumux_sel     (alumux_sel),
    .regfilemux_sel (regfilemux_sel),
    .marmux_sel     (marmux_sel),
    .mdrmux_sel     (mdrmux_sel),
    .aluop          (aluop),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_error      (mem_error)
  );

  always #5 clk = ~clk;

  assign obs = {load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc,
                pcmux_sel, storemux_sel, alumux_sel, regfilemux_sel, marmux_sel,
                mdrmux_sel, aluop, mem_read, mem_write, mem_error};

  function automatic logic [17:0] aluf(input logic [2:0] op);
    return {12'h000, op, 3'b000};
  endfunction

  task automatic check(input string tag, input logic [17:0] e);
    vectors++;
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
    end
  endtask

  task automatic push(input string t, input logic [17:0] e, input logic r,
                      input logic [3:0] op, input logic be);
    tag_q.push_back(t);
    exp_q.push_back(e);
    resp_q.push_back(r);
    op_q.push_back(op);
    be_q.push_back(be);
  endtask

  // Inputs that the controller must ignore in this cycle get random values.
  task automatic push_n(input string t, input logic [17:0] e);
    push(t, e, 1'($urandom_range(1)), 4'($urandom_range(15)), 1'($urandom_range(1)));
  endtask

  // w = cycle on which mem_resp arrives (1..TIMEOUT); 0 = never, so the watchdog fires.
  task automatic push_wait(input string t, input logic [17:0] e, input int unsigned w,
                           output bit err);
    err = (w == 0);
    for (int unsigned k = 1; k <= (err ? TIMEOUT : w); k++) begin
      push(t, e, (k == w), 4'($urandom_range(15)), 1'($urandom_range(1)));
    end
    if (err) begin
      push_n("error_entry", 18'h0);
      for (int k = 0; k < 3; k++) push_n("error_sticky", ERRB);
    end
  endtask

  task automatic build(input logic [3:0] op, input logic be, input int unsigned wf,
                       input int unsigned wm, output bit err);
    exp_q.delete(); resp_q.delete(); op_q.delete(); be_q.delete(); tag_q.delete();
    push_n("fetch1", LPC | LMAR);
    push_wait("fetch2", RD | LMDR, wf, err);
    if (!err) begin
      push_n("fetch3", LIR);
      push("decode", 18'h0, 1'($urandom_range(1)), op, 1'($urandom_range(1)));
      case (op)
        4'b0001: push_n("add", LRF | LCC | aluf(alu_add));
        4'b0101: push_n("and", LRF | LCC | aluf(alu_and));
        4'b1001: push_n("not", LRF | LCC | aluf(alu_not));
        4'b0000: begin
          push("br", 18'h0, 1'($urandom_range(1)), 4'($urandom_range(15)), be);
          if (be) push_n("br_taken", PCM | LPC);
        end
        4'b0110, 4'b0111: begin
          push("calc_addr", ALM | MARM | LMAR, 1'($urandom_range(1)), op,
               1'($urandom_range(1)));
          if (op == 4'b0110) begin
            push_wait("ldr1", RD | LMDR, wm, err);
            if (!err) push_n("ldr2", RFM | LRF | LCC);
          end else begin
            push_n("str1", STM | MDRM | LMDR | aluf(alu_pass));
            push_wait("str2", WR, wm, err);
          end
        end
        default: ;
      endcase
    end
  endtask

  // Sample each cycle at the falling edge, then drive that cycle's inputs.
  task automatic run_seq(input int stop_at);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      check(tag_q[i], exp_q[i]);
      if (i == stop_at) break;
      opcode        = op_q[i];
      branch_enable = be_q[i];
      mem_resp      = resp_q[i];
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1 check("reset_async", 18'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      mem_resp = ~mem_resp;
      #1 check("reset_hold", 18'h0);
    end
    @(negedge clk);
    reset_n  = 1'b1;
    mem_resp = 1'($urandom_range(1));
  endtask

  initial begin
    logic [3:0]  op;
    logic        be;
    int unsigned wf, wm, pick;
    bit          err;

    reset_n       = 1'b1;
    opcode        = 4'h0;
    branch_enable = 1'b0;
    mem_resp      = 1'b0;
    #2 do_reset();

    build(4'b0001, 1'b0, 3, 1, err); run_seq(-1);
    build(4'b0000, 1'b1, 1, 1, err); run_seq(-1);
    build(4'b0000, 1'b0, 2, 1, err); run_seq(-1);
    build(4'b0110, 1'b0, 1, 2, err); run_seq(-1);
    build(4'b0111, 1'b0, 2, 3, err); run_seq(-1);
    build(4'b0101, 1'b0, 1, 1, err); run_seq(-1);
    build(4'b1001, 1'b0, 1, 1, err); run_seq(-1);

    build(4'b0001, 1'b0, 0, 1, err); run_seq(-1); do_reset();
    build(4'b0110, 1'b0, 1, 0, err); run_seq(-1); do_reset();
    build(4'b0111, 1'b0, 1, 0, err); run_seq(-1); do_reset();

    build(4'b0001, 1'b0, TIMEOUT, 1, err); run_seq(-1);
    build(4'b0110, 1'b0, 2, TIMEOUT, err); run_seq(-1);
    build(4'b1111, 1'b0, 1, 1, err); run_seq(-1);

    build(4'b0111, 1'b0, 1, 3, err);
    run_seq(exp_q.size() - 2);
    do_reset();

    for (int n = 0; n < 120; n++) begin
      pick = $urandom_range(6);
      case (pick)
        0:       op = 4'b0001;
        1:       op = 4'b0101;
        2:       op = 4'b1001;
        3:       op = 4'b0000;
        4:       op = 4'b0110;
        5:       op = 4'b0111;
        default: op = 4'($urandom_range(15));
      endcase
      be = 1'($urandom_range(1));
      wf = ($urandom_range(15) == 0) ? 0 : $urandom_range(TIMEOUT, 1);
      wm = ($urandom_range(15) == 0) ? 0 : $urandom_range(TIMEOUT, 1);
      build(op, be, wf, wm, err);
      run_seq(-1);
      if (err) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
